// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA/NES geometry constants, colour type and scanline helper
package vga_pkg;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int NES_W = 256;
    localparam int NES_H = 240;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    function automatic rgb12_t half_rgb(input rgb12_t c);
        return '{r: {1'b0, c.r[3:1]}, g: {1'b0, c.g[3:1]}, b: {1'b0, c.b[3:1]}};
    endfunction
endpackage

// File: rtl/nes_palette_rom.sv
// nes_palette_rom: 64x12 NES palette lookup, synchronous read with 1-cycle latency
module nes_palette_rom
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic [5:0] addr,
    output rgb12_t     q
);
    localparam logic [11:0] PAL [64] = '{
        12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
        12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
        12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
        12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
        12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
        12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
        12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
        12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
    };

    // registered palette lookup
    always_ff @(posedge clk) q <= rgb12_t'(PAL[addr]);
endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: framebuffer fetch, 2x line doubling and palette conversion; VGA_SCANLINE_EN halves replay-line intensity
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int          H_OFFSET   = 64,
    parameter logic [11:0] BORDER_RGB = 12'h000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        valid,
    input  logic        hsync,
    input  logic        vsync,
    output logic [15:0] fb_addr,
    output logic        fb_rd_en,
    input  logic [5:0]  fb_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync
);
    logic [9:0]  dx;
    logic        win, fetch, rd;
    logic        s1_valid, s1_win, s1_load, s1_rep, s1_blk, s1_hs, s1_vs;
    logic [7:0]  s1_hx;
    logic        s2_valid, s2_win, s2_rep, s2_blk, s2_hs, s2_vs;
    logic        lb_ok;
    logic [5:0]  linebuf [NES_W];
    logic [5:0]  idx, idx_next;
    rgb12_t      pal_q;
    logic [11:0] pix, rgb;

    // window test uses dx[9] so x below H_OFFSET+512 is checked without a second subtract
    assign dx    = x_pos - 10'(H_OFFSET);
    assign win   = valid && x_pos >= 10'(H_OFFSET) && !dx[9] && y_pos < 10'(V_RES);
    assign fetch = win && !y_pos[0];
    assign rd    = fetch && !dx[0];

    // stage 1: framebuffer request, linebuf address and control bits
    always_ff @(posedge clk) begin
        if (!reset) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_win   <= 1'b0;
            s1_load  <= 1'b0;
            s1_rep   <= 1'b0;
            s1_blk   <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_hx    <= '0;
            lb_ok    <= 1'b0;
        end else begin
            if (rd) fb_addr <= {y_pos[8:1], dx[8:1]};
            fb_rd_en <= rd;
            s1_valid <= valid;
            s1_win   <= win;
            s1_load  <= win && !dx[0];
            s1_rep   <= win && y_pos[0];
            s1_blk   <= win && y_pos[0] && !lb_ok;
            s1_hs    <= hsync;
            s1_vs    <= vsync;
            s1_hx    <= dx[8:1];
            if (fetch && dx[8:0] == 9'd511) lb_ok <= 1'b1;
        end
    end

    // line buffer fill from each framebuffer return; contents survive reset
    always_ff @(posedge clk) begin
        if (fb_rd_en) linebuf[s1_hx] <= fb_data;
    end

    // odd columns keep the previous even column's index so each NES pixel is two wide
    always_comb idx_next = s1_load ? (s1_rep ? linebuf[s1_hx] : fb_data) : idx;

    // stage 2: index register and control pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx      <= '0;
            s2_valid <= 1'b0;
            s2_win   <= 1'b0;
            s2_rep   <= 1'b0;
            s2_blk   <= 1'b0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
        end else begin
            idx      <= idx_next;
            s2_valid <= s1_valid;
            s2_win   <= s1_win;
            s2_rep   <= s1_rep;
            s2_blk   <= s1_blk;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
        end
    end

    nes_palette_rom u_pal (
        .clk  (clk),
        .addr (idx_next),
        .q    (pal_q)
    );

    // colour selection: blanking, border, un-primed replay lines, optional scanline dimming
    always_comb begin
        pix = !s2_valid ? 12'h000 : !s2_win ? BORDER_RGB : s2_blk ? 12'h000 : pal_q;
`ifdef VGA_SCANLINE_EN
        if (s2_rep) pix = half_rgb(pix);
`endif
    end

    // stage 3: registered colour and delayed syncs
    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb       <= '0;
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
        end else begin
            rgb       <= pix;
            vga_hsync <= s2_hs;
            vga_vsync <= s2_vs;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb;
endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Pixel pipeline directly downstream of the VGA timing generator. It consumes `x_pos`/`y_pos`/`valid`/`hsync`/`vsync` and fetches 6-bit NES palette indices from the 256x240 framebuffer. It line-doubles them through an internal 256-entry line buffer and converts them to 12-bit RGB through the NES palette. Sync outputs are delayed to stay aligned with the colour outputs. The NES image is scaled 2x into a 512x480 window centred in the 640x480 frame, with a 64-pixel border on each side.

## Interface
Parameters:
- `H_OFFSET`, default 64: first active-picture x column.
- `BORDER_RGB`, default 12'h000: colour for valid pixels outside the picture window.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-low; asserted when 0, sampled on `clk` rising edge.
- `x_pos` in 10: horizontal counter from the timing generator, 0..799.
- `y_pos` in 10: vertical counter, 0..524.
- `valid` in 1: visible-area flag.
- `hsync` in 1: horizontal sync, passed through with delay.
- `vsync` in 1: vertical sync, passed through with delay.
- `fb_addr` out 16: framebuffer read address `{ny[7:0], hx[7:0]}`; registered.
- `fb_rd_en` out 1: framebuffer read strobe; registered.
- `fb_data` in 6: palette index, valid the cycle after the edge that registers `fb_addr`.
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour outputs; registered.
- `vga_hsync`, `vga_vsync` out 1 each: delayed syncs; registered.

## Operation
- Picture window: `valid && x_pos >= H_OFFSET && x_pos < H_OFFSET+512`.
  - `hx = (x_pos-H_OFFSET)>>1`, 8 bits.
  - `ny = y_pos>>1`, 8 bits, range 0..239.
- Fetch lines: in-window pixels with `y_pos[0]==0`.
  - `fb_rd_en=1` only on even window columns, i.e. `(x_pos-H_OFFSET)[0]==0`. Exactly 256 reads per fetch line.
  - Each returned index is written to `linebuf[hx]` and also forwarded to the pixel path.
- Replay lines: `y_pos[0]==1`.
  - `fb_rd_en=0`; the index is read from `linebuf[hx]`.
  - `linebuf` is an internal synchronous RAM with 1-cycle read latency, matching the framebuffer.
- Odd window columns hold the index captured for the preceding even column, so each NES pixel is 2 wide.
- Palette: the 6-bit index maps through a 64-entry ROM to 12-bit RGB.
- Colour selection:
  - `valid=0`: output RGB 0.
  - `valid=1` outside the window: output `BORDER_RGB`.
- `lb_ok` flag:
  - Cleared on reset.
  - Set on the first fetch-line pixel in window column 511.
  - Replay lines with `lb_ok=0` output RGB 0, covering a reset mid-frame.
- Width rules: all subtractions on 10 bits. Comparisons are unsigned. No wrap can occur inside the window.

## Timing
- Pipeline: 3 stages, all outputs registered.
  - Edge k: sample the inputs; register `fb_addr`/`fb_rd_en`, the linebuf read address, and the control bits (window, valid, line parity, syncs).
  - Edge k+1: capture `fb_data` or linebuf data into the index register. The linebuf write occurs on this same edge.
  - Edge k+2: palette ROM output registered into the RGB register.
- Latency from inputs to `vga_*`: 3 edges, with the syncs delayed identically.
- `fb_addr`/`fb_rd_en` lead the colour outputs by 2 cycles.
- Reset (`reset==0` at an edge):
  - `fb_addr=0`, `fb_rd_en=0`.
  - RGB=0, `vga_hsync=0`, `vga_vsync=0`.
  - All pipeline valid/sync bits cleared; `lb_ok=0`.
  - Linebuf contents are not reset.
- Reset mid-line: the outputs show reset values until 3 edges after release.

## Configuration
- `VGA_SCANLINE_EN` defined: on replay lines, each channel is output as `{1'b0, c[3:1]}`, giving a half-intensity scanline effect.
- Undefined: replay lines are identical to fetch lines.

## Structure
- Package `vga_pkg`:
  - Constants `H_RES=640`, `V_RES=480`, `NES_W=256`, `NES_H=240`.
  - Typedef `rgb12_t` (struct r/g/b, 4 bits each).
- Sub-module `nes_palette_rom`: 64x12 synchronous ROM with 1-cycle latency, instantiated once.
- The line buffer is inferred inline.

## Test plan
- Reset: hold `reset=0` 5 cycles with the timing generator running -> all outputs 0, and 0 for 3 edges after release.
- Fetch line y=0, framebuffer returns `fb_data = hx[5:0]`:
  - `fb_rd_en` pulses 256 times.
  - `fb_addr` runs 0x0000..0x00FF on x=64,66,...,574.
  - RGB at x=64/65 equals `palette[0]`, appearing 3 cycles later.
- Replay y=1 with `fb_data` forced to 6'h3F:
  - No `fb_rd_en`.
  - Colours equal the y=0 line; with `VGA_SCANLINE_EN` each channel is shifted right by 1.
- Border/blank with `BORDER_RGB=12'h00F`:
  - x=10, y=5 -> output 12'h00F.
  - x=700 (valid=0) -> output 0.
  - `vga_hsync` high exactly for x=656..751 delayed by 3.
- Last line: y=479 -> `fb_addr` high byte is 239 (0xEF) from the preceding fetch line. At y=524 -> x=799 wrap, no reads are issued.
- Mid-frame reset released at y=101: replay line y=101 outputs black (`lb_ok=0`). Line y=103 shows correct colours after fetch line y=102.
